// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: datapath width, NOP word,
// fetch FSM states and the IF/ID pipeline bundle.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, clear-to-bubble, load enable.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= IFID_BUBBLE;
    end else if (clr) begin
      q <= IFID_BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request, IF/ID register and a
// saturating count of bubbles caused by instruction-memory waits.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             pcsrcD,
  input  logic [XLEN-1:0]  pc_branchD,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      instrD,
  output logic [XLEN-1:0]  pc_plus4D,
  output logic             validD,
  output logic             misalign_err,
  output logic [CNT_W-1:0] wait_cnt
);

  fetch_state_t    state, stateNext;
  logic [XLEN-1:0] pcF, pcNext;
  logic            ifidEn, ifidClr, cntInc, misSet;
  ifid_t           ifidD, ifidQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pcF          <= RESET_PC;
      misalign_err <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state <= stateNext;
      pcF   <= pcNext;
      if (misSet) begin
        misalign_err <= 1'b1;
      end
      if (cntInc && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // PC and IF/ID priorities are independent chains; stallD only gates IF/ID.
  always_comb begin
    stateNext      = state;
    pcNext         = pcF;
    ifidEn         = 1'b0;
    ifidClr        = 1'b0;
    cntInc         = 1'b0;
    misSet         = 1'b0;
    ifidD.instr    = imem_rdata;
    ifidD.pc_plus4 = pcF + XLEN'(4);
    ifidD.valid    = 1'b1;
    unique case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        if (!stallF) begin
          if (pcsrcD) begin
            pcNext = {pc_branchD[XLEN-1:2], 2'b00};
            misSet = |pc_branchD[1:0];
          end else if (imem_ready) begin
            pcNext = pcF + XLEN'(4);
          end
        end
        if (!stallD) begin
          if (pcsrcD || stallF) begin
            ifidClr = 1'b1;
          end else if (!imem_ready) begin
            ifidClr = 1'b1;
            cntInc  = 1'b1;
          end else begin
            ifidEn = 1'b1;
          end
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ifidEn),
    .clr   (ifidClr),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign imem_addr = pcF;
  assign instrD    = ifidQ.instr;
  assign pc_plus4D = ifidQ.pc_plus4;
  assign validD    = ifidQ.valid;

endmodule
